// File: rtl/float_adder_pipe.sv
// float_adder_pipe: three-stage IEEE-754 binary adder/subtractor with
// valid/ready flow control, round-to-nearest-even, subnormals and specials.
//   S1 align     : unpack, resolve specials, swap so |X| >= |Y|, align Y.
//   S2 add/norm  : magnitude add or subtract, normalise (subnormal floor).
//   S3 round/pack: RNE rounding, overflow to infinity, special override.
// Optional feature: define FLOAT_ADDER_PIPE_FLAGS_EN to compute and register
// {invalid, overflow, inexact}; otherwise flags is tied to zero and c is
// unaffected.
//
// Handshake: a stage transfers on valid & ready. Each stage register loads
// when it is empty or when the next stage loads from it, so bubbles collapse
// and one result per cycle flows at full throughput. c and flags hold while
// out_valid is high and out_ready is low.
module float_adder_pipe #(
  parameter int E = 8,
  parameter int M = 23
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [E+M:0] a,
  input  logic [E+M:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [E+M:0] c,
  output logic [2:0]   flags
);

  localparam int W = E + M + 1;
  // Aligned significand field: {hidden, mant, guard, round, sticky}.
  localparam int F = M + 4;
  localparam logic [W-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

  // ---------------------------------------------------------------- control
  logic s1_valid, s2_valid, s3_valid;
  logic s1_rdy, s2_rdy, s3_rdy;
  logic s1_ld, s2_ld, s3_ld;

  assign s3_rdy    = !s3_valid || out_ready;
  assign s2_rdy    = !s2_valid || s3_rdy;
  assign s1_rdy    = !s1_valid || s2_rdy;
  assign in_ready  = s1_rdy;
  assign s1_ld     = in_valid && s1_rdy;
  assign s2_ld     = s1_valid && s2_rdy;
  assign s3_ld     = s2_valid && s3_rdy;
  assign out_valid = s3_valid;

  // Stage valid bits advance when the downstream side can take them.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      if (s1_rdy) s1_valid <= in_valid;
      if (s2_rdy) s2_valid <= s1_valid;
      if (s3_rdy) s3_valid <= s2_valid;
    end
  end

  // ---------------------------------------------------------- stage 1 align
  logic         sa, sb, sx, sy, swap;
  logic [E-1:0] ea, eb, ex_raw, ey_raw, ex_eff, ey_eff, de;
  logic [M-1:0] ma, mb, mx, my;
  logic [F-1:0] x_al, y_al;
  logic [2*F-1:0] y_ext;
  logic         a_nan, b_nan, a_inf, b_inf;
  logic         sp;
  logic [W-1:0] sp_val;

  assign sa = a[W-1];
  assign ea = a[W-2:M];
  assign ma = a[M-1:0];
  // Subtraction is folded in by flipping the sign of b up front.
  assign sb = b[W-1] ^ sub;
  assign eb = b[W-2:M];
  assign mb = b[M-1:0];

  // Raw {exp,mant} ordering matches magnitude ordering, subnormals included.
  assign swap   = {eb, mb} > {ea, ma};
  assign sx     = swap ? sb : sa;
  assign sy     = swap ? sa : sb;
  assign ex_raw = swap ? eb : ea;
  assign ey_raw = swap ? ea : eb;
  assign mx     = swap ? mb : ma;
  assign my     = swap ? ma : mb;

  // Subnormals use effective exponent 1 with a zero hidden bit.
  assign ex_eff = (ex_raw == '0) ? {{(E-1){1'b0}}, 1'b1} : ex_raw;
  assign ey_eff = (ey_raw == '0) ? {{(E-1){1'b0}}, 1'b1} : ey_raw;
  assign de     = ex_eff - ey_eff;

  assign x_al  = {|ex_raw, mx, 3'b000};
  assign y_ext = {|ey_raw, my, 3'b000, {F{1'b0}}} >> de;

  // Align Y to X; everything shifted past the field folds into sticky.
  always_comb begin
    y_al = '0;
    if (int'(de) >= M + 3) begin
      y_al[0] = |{ey_raw, my};
    end else begin
      y_al    = y_ext[2*F-1:F];
      y_al[0] = y_ext[F] | (|y_ext[F-1:0]);
    end
  end

  assign a_nan = (&ea) && (|ma);
  assign b_nan = (&eb) && (|mb);
  assign a_inf = (&ea) && !(|ma);
  assign b_inf = (&eb) && !(|mb);

  // Special operands resolve to a fixed result that overrides the datapath.
  always_comb begin
    sp     = 1'b0;
    sp_val = '0;
    if (a_nan || b_nan) begin
      sp     = 1'b1;
      sp_val = QNAN;
    end else if (a_inf && b_inf) begin
      sp     = 1'b1;
      sp_val = (sa != sb) ? QNAN : {sa, {E{1'b1}}, {M{1'b0}}};
    end else if (a_inf) begin
      sp     = 1'b1;
      sp_val = {sa, {E{1'b1}}, {M{1'b0}}};
    end else if (b_inf) begin
      sp     = 1'b1;
      sp_val = {sb, {E{1'b1}}, {M{1'b0}}};
    end
  end

`ifdef FLOAT_ADDER_PIPE_FLAGS_EN
  logic sp_inv, s1_inv, s2_inv;
  // invalid: signalling NaN operand, or inf minus inf with no NaN present.
  assign sp_inv = (a_nan || b_nan) ? ((a_nan && !ma[M-1]) || (b_nan && !mb[M-1]))
                                   : (a_inf && b_inf && (sa != sb));
`endif

  logic         s1_sx, s1_op, s1_sp;
  logic [E-1:0] s1_ex;
  logic [F-1:0] s1_xm, s1_ym;
  logic [W-1:0] s1_sp_val;

  // Stage 1 register: aligned operands plus the special-case tag.
  always_ff @(posedge clk) begin
    if (s1_ld) begin
      s1_sx     <= sx;
      s1_op     <= sx ^ sy;
      s1_ex     <= ex_eff;
      s1_xm     <= x_al;
      s1_ym     <= y_al;
      s1_sp     <= sp;
      s1_sp_val <= sp_val;
`ifdef FLOAT_ADDER_PIPE_FLAGS_EN
      s1_inv    <= sp_inv;
`endif
    end
  end

  // ------------------------------------------------ stage 2 add / normalise
  // Leading-zero count; the last hit scanning upward is the top set bit.
  function automatic int lzc(input logic [F-1:0] v);
    int n;
    n = F;
    for (int i = 0; i < F; i++) begin
      if (v[i]) n = F - 1 - i;
    end
    return n;
  endfunction

  logic [F:0]   sum;
  logic [F-1:0] n2_man;
  logic [E-1:0] n2_exp;
  logic         n2_sign;
  int           lz, lim, sh;

  // X >= Y in magnitude, so the difference never goes negative.
  assign sum = s1_op ? ({1'b0, s1_xm} - {1'b0, s1_ym})
                     : ({1'b0, s1_xm} + {1'b0, s1_ym});

  // Normalise: carry shifts right once, otherwise shift left down to exp 1.
  always_comb begin
    n2_man = '0;
    n2_exp = '0;
    lz     = 0;
    lim    = 0;
    sh     = 0;
    if (sum[F]) begin
      n2_man    = sum[F:1];
      n2_man[0] = sum[1] | sum[0];
      n2_exp    = s1_ex + 1'b1;
    end else begin
      lz     = lzc(sum[F-1:0]);
      lim    = int'(s1_ex) - 1;
      sh     = (lz < lim) ? lz : lim;
      n2_man = sum[F-1:0] << sh;
      n2_exp = s1_ex - E'(sh);
    end
    // Exact cancellation of opposite signs yields +0.
    n2_sign = (s1_op && (sum == '0)) ? 1'b0 : s1_sx;
  end

  logic         s2_sign, s2_sp;
  logic [E-1:0] s2_exp;
  logic [F-1:0] s2_man;
  logic [W-1:0] s2_sp_val;

  // Stage 2 register: normalised significand with G/R/S still attached.
  always_ff @(posedge clk) begin
    if (s2_ld) begin
      s2_sign   <= n2_sign;
      s2_exp    <= n2_exp;
      s2_man    <= n2_man;
      s2_sp     <= s1_sp;
      s2_sp_val <= s1_sp_val;
`ifdef FLOAT_ADDER_PIPE_FLAGS_EN
      s2_inv    <= s1_inv;
`endif
    end
  end

  // -------------------------------------------------- stage 3 round / pack
  logic         lsb, g, r, s, up, ovf;
  logic [M+1:0] rm;
  logic [E:0]   e3;
  logic         h3;
  logic [M-1:0] m3;
  logic [W-1:0] res;

  assign lsb = s2_man[3];
  assign g   = s2_man[2];
  assign r   = s2_man[1];
  assign s   = s2_man[0];
  assign up  = g & (r | s | lsb);
  assign rm  = {1'b0, s2_man[F-1:3]} + {{(M+1){1'b0}}, up};

  // Round to nearest even; a mantissa carry bumps the exponent.
  always_comb begin
    if (rm[M+1]) begin
      m3 = '0;
      h3 = 1'b1;
      e3 = {1'b0, s2_exp} + 1'b1;
    end else begin
      m3 = rm[M-1:0];
      h3 = rm[M];
      e3 = {1'b0, s2_exp};
    end
    ovf = (e3 >= {1'b0, {E{1'b1}}});
  end

  // Final result: special override, overflow to infinity, or packed value.
  always_comb begin
    if (s2_sp) begin
      res = s2_sp_val;
    end else if (ovf) begin
      res = {s2_sign, {E{1'b1}}, {M{1'b0}}};
    end else begin
      // A clear hidden bit means the value sits at the subnormal floor.
      res = {s2_sign, (h3 ? e3[E-1:0] : {E{1'b0}}), m3};
    end
  end

  // Output register for c; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      c <= '0;
    end else if (s3_ld) begin
      c <= res;
    end
  end

`ifdef FLOAT_ADDER_PIPE_FLAGS_EN
  logic [2:0] res_flags;

  // Flags: invalid only from specials; inexact from the pre-rounding bits.
  always_comb begin
    if (s2_sp) begin
      res_flags = {s2_inv, 2'b00};
    end else if (ovf) begin
      res_flags = 3'b011;
    end else begin
      res_flags = {2'b00, (g | r | s)};
    end
  end

  // Output register for flags, aligned with c.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= 3'b000;
    end else if (s3_ld) begin
      flags <= res_flags;
    end
  end
`else
  assign flags = 3'b000;
`endif

endmodule

// File: tb/tb_float_adder_pipe.sv
// Testbench for float_adder_pipe (E=8, M=23): directed IEEE cases, random
// exact integer sums, backpressure streaming and a mid-stream reset.
module tb_float_adder_pipe;

  localparam int W  = 32;
  localparam int QW = W + 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] c;
  logic [2:0]   flags;

  int errors = 0;
  int checks = 0;
  int sent   = 0;
  logic [QW-1:0] exp_q[$];

  float_adder_pipe #(.E(8), .M(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .flags(flags)
  );

  // ------------------------------------------------------ clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // --------------------------------------------------------------- checker
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Flags are only produced when the optional feature is built in.
  function automatic logic [2:0] fx(input logic [2:0] f);
`ifdef FLOAT_ADDER_PIPE_FLAGS_EN
    return f;
`else
    return 3'b000;
`endif
  endfunction

  // Exact conversion of an integer with magnitude below 2^24 to binary32.
  function automatic logic [31:0] i2f(input int v);
    logic        sg;
    int unsigned m;
    int          p;
    if (v == 0) return 32'h0;
    sg = (v < 0);
    m  = sg ? int'(-v) : v;
    p  = 31;
    while (!m[p]) p--;
    m = m << (23 - p);
    return {sg, 8'(127 + p), m[22:0]};
  endfunction

  // ---------------------------------------------------------------- driver
  // Called at a falling edge; returns at a later falling edge, in_valid low.
  task automatic send(input logic [31:0] xa, input logic [31:0] xb, input logic xs,
                      input logic [31:0] ec, input logic [2:0] ef);
    int tries;
    in_valid = 1'b1;
    a        = xa;
    b        = xb;
    sub      = xs;
    tries    = 0;
    #1;
    while (!in_ready && tries < 200) begin
      @(negedge clk);
      #1;
      tries++;
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1);
    end else begin
      exp_q.push_back({ec, fx(ef)});
      sent++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 0);
  endtask

  // ------------------------------------------------------------ scoreboard
  initial begin
    logic [QW-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", out_valid, 0);
        end else if (out_ready) begin
          e = exp_q.pop_front();
          check("c", c, e[QW-1:3]);
          check("flags", flags, e[2:0]);
        end else begin
          check("hold", {c, flags}, exp_q[0]);
        end
      end
    end
  end

  // -------------------------------------------------------------- stimulus
  logic [31:0] da[21] = '{32'h3F800000, 32'h80000000, 32'h40400000, 32'h3F800000,
                          32'h3F800001, 32'h7F7FFFFF, 32'h7F800000, 32'h7F800001,
                          32'h00000001, 32'h00400000, 32'h3FFFFFFF, 32'h7F7FFFFF,
                          32'h00800000, 32'h7F800000, 32'h7FC00000, 32'hBF800000,
                          32'h00000000, 32'h7F800000, 32'h3F800000, 32'h3F800000,
                          32'h3F800000};
  logic [31:0] db[21] = '{32'hBF800000, 32'h80000000, 32'h40400000, 32'h33800000,
                          32'h33800000, 32'h7F7FFFFF, 32'hFF800000, 32'h3F800000,
                          32'h00000001, 32'h00400000, 32'h33800000, 32'h73000000,
                          32'h00000001, 32'h3F800000, 32'h3F800000, 32'h3F000000,
                          32'h80000000, 32'h7F800000, 32'h40000000, 32'h33000000,
                          32'h33800000};
  logic        ds[21] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0,
                          0, 1, 1, 0, 0, 0, 1, 1, 0, 1};
  logic [31:0] dc[21] = '{32'h00000000, 32'h80000000, 32'h00000000, 32'h3F800000,
                          32'h3F800002, 32'h7F800000, 32'h7FC00000, 32'h7FC00000,
                          32'h00000002, 32'h00800000, 32'h40000000, 32'h7F800000,
                          32'h007FFFFF, 32'h7F800000, 32'h7FC00000, 32'hBF000000,
                          32'h00000000, 32'h7FC00000, 32'hBF800000, 32'h3F800000,
                          32'h3F7FFFFF};
  logic [2:0]  df[21] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b011, 3'b100,
                          3'b100, 3'b000, 3'b000, 3'b001, 3'b011, 3'b000, 3'b000,
                          3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};

  initial begin
    int lat, ra, rb;
    logic rs;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_c", c, 0);
    check("rst_flags", flags, 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);

    // Latency: out_valid three cycles after the accepting cycle.
    @(negedge clk);
    send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
    lat = 1;
    #1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 3);
    drain();

    // Directed IEEE cases, streamed back to back.
    for (int i = 0; i < 21; i++) send(da[i], db[i], ds[i], dc[i], df[i]);
    drain();

    // Random integer operands: sums are exact, so the model is i2f(a +/- b).
    for (int i = 0; i < 24; i++) begin
      ra = int'($urandom_range(0, 200000)) - 100000;
      rb = int'($urandom_range(0, 200000)) - 100000;
      rs = 1'($urandom_range(0, 1));
      send(i2f(ra), i2f(rb), rs, i2f(rs ? ra - rb : ra + rb), 3'b000);
    end
    drain();

    // Backpressure: consumer stalls for 5 cycles while 8 pairs stream in.
    sent      = 0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(i2f(i * 3 + 1), i2f(100 - i), 1'b0, i2f(101 + 2 * i), 3'b000);
        end
      end
      begin
        repeat (4) @(negedge clk);
        #1;
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_accepted", 64'(sent), 3);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_sent", 64'(sent), 8);

    // Reset with results in flight discards them.
    out_ready = 1'b0;
    send(i2f(7), i2f(9), 1'b0, i2f(16), 3'b000);
    send(i2f(5), i2f(2), 1'b1, i2f(3), 3'b000);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_c", c, 0);
    check("mid_rst_flags", flags, 0);
    exp_q.delete();
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    repeat (4) @(negedge clk);
    check("mid_rst_no_output", out_valid, 0);

    // Recovery after reset.
    send(i2f(2), i2f(3), 1'b0, i2f(5), 3'b000);
    send(i2f(-40), i2f(-2), 1'b1, i2f(-38), 3'b000);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
